dfi_write_sequencer: RTL

DFI_WRITE_SEQUENCER -- requirements
Module: dfi_write_sequencer

---
 rtl/dfi_pkg.sv | 39 +++
 rtl/dfi_timer.sv | 37 +++
 rtl/dfi_write_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/dfi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dfi_pkg
// Purpose  : Shared constants for the DFI write sequencer: SDRAM command
//            encodings {cs_n, ras_n, cas_n, we_n}, FSM state codes, the wait
//            timer width and a helper that names the states which start a
//            timed wait.
// Revision : 1.0 - initial release
// ============================================================================
package dfi_pkg;

    // SDRAM commands as {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] c_cmd_nop   = 4'b0111;
    localparam logic [3:0] c_cmd_act   = 4'b0011;
    localparam logic [3:0] c_cmd_write = 4'b0100;
    localparam logic [3:0] c_cmd_pre   = 4'b0010;

    // Sequencer states
    localparam logic [3:0] c_st_idle  = 4'd0;
    localparam logic [3:0] c_st_act   = 4'd1;
    localparam logic [3:0] c_st_trcd  = 4'd2;
    localparam logic [3:0] c_st_write = 4'd3;
    localparam logic [3:0] c_st_wlat  = 4'd4;
    localparam logic [3:0] c_st_data  = 4'd5;
    localparam logic [3:0] c_st_twr   = 4'd6;
    localparam logic [3:0] c_st_pre   = 4'd7;
    localparam logic [3:0] c_st_trp   = 4'd8;

    localparam int c_timer_w = 8;

    // States whose entry starts a timed interval: the shared counter is
    // loaded with (interval - 1) when one of these is entered.
    function automatic logic starts_wait(input logic [3:0] st);
        return (st == c_st_act) || (st == c_st_write) ||
               (st == c_st_twr) || (st == c_st_pre);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dfi_timer.sv
`default_nettype none
// ============================================================================
// Module   : dfi_timer
// Purpose  : Loadable down-counter with zero flag. Counts down to zero and
//            holds there; a load takes priority over counting.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            i_load        - load i_value this cycle
//            i_value       - value to load
//            o_zero        - counter currently equals zero
// Revision : 1.0 - initial release
// ============================================================================
module dfi_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/dfi_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dfi_write_sequencer
// Purpose  : Issues one single-burst SDRAM write per request on a 2-phase
//            DFI: ACT, WRITE, one data beat on both phases, PRE, then idle.
//            All DFI outputs are registered from the next-state decode so a
//            command appears in the first cycle of its state.
// Ports    : sys_clk, sys_rst           - clock, synchronous active-high reset
//            req_valid/req_ready        - request handshake (ready only idle)
//            req_row/col/ba/data/mask   - request payload, low half = phase 0
//            dfi_*_p0 / dfi_*_p1        - DFI command/address/write-data
//            busy                       - sequencer not idle
// Revision : 1.0 - initial release
// ============================================================================
module dfi_write_sequencer
    import dfi_pkg::*;
#(
    parameter int NUM_AD = 13,
    parameter int NUM_BA = 2,
    parameter int NUM_D  = 64,
    parameter int TRCD   = 2,
    parameter int WRLAT  = 1,
    parameter int TWR    = 2,
    parameter int TRP    = 2
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [NUM_AD-1:0]    req_row,
    input  logic [NUM_AD-1:0]    req_col,
    input  logic [NUM_BA-1:0]    req_ba,
    input  logic [2*NUM_D-1:0]   req_data,
    input  logic [NUM_D/4-1:0]   req_mask,
    output logic [NUM_AD-1:0]    dfi_address_p0,
    output logic [NUM_AD-1:0]    dfi_address_p1,
    output logic [NUM_BA-1:0]    dfi_bank_p0,
    output logic [NUM_BA-1:0]    dfi_bank_p1,
    output logic                 dfi_cs_n_p0,
    output logic                 dfi_ras_n_p0,
    output logic                 dfi_cas_n_p0,
    output logic                 dfi_we_n_p0,
    output logic                 dfi_wrdata_en_p0,
    output logic                 dfi_wrdata_en_p1,
    output logic [NUM_D-1:0]     dfi_wrdata_p0,
    output logic [NUM_D-1:0]     dfi_wrdata_p1,
    output logic [NUM_D/8-1:0]   dfi_wrdata_mask_p0,
    output logic [NUM_D/8-1:0]   dfi_wrdata_mask_p1,
    output logic                 busy
);

    localparam logic [c_timer_w-1:0] c_ld_trcd  = c_timer_w'(TRCD - 1);
    localparam logic [c_timer_w-1:0] c_ld_wrlat = c_timer_w'(WRLAT - 1);
    localparam logic [c_timer_w-1:0] c_ld_twr   = c_timer_w'(TWR - 1);
    localparam logic [c_timer_w-1:0] c_ld_trp   = c_timer_w'(TRP - 1);
    // A10 selects auto-precharge on WRITE; it is always cleared because an
    // explicit PRE follows. Shifts out to zero on narrow address buses.
    localparam logic [NUM_AD-1:0]    c_a10      = NUM_AD'(1) << 10;

    logic [3:0]             r_state;
    logic [3:0]             w_next;
    logic                   w_accept;
    logic                   w_zero;
    logic                   w_load;
    logic [c_timer_w-1:0]   w_load_val;

    logic [NUM_AD-1:0]      r_col;
    logic [NUM_BA-1:0]      r_ba;
    logic [2*NUM_D-1:0]     r_data;
    logic [NUM_D/4-1:0]     r_mask;

    assign w_accept = (r_state == c_st_idle) && req_ready && req_valid;

    // ACT/WRITE/PRE each decide on their own cycle whether the following
    // wait state is needed; a loaded value of zero skips it entirely.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle:  if (w_accept) w_next = c_st_act;
            c_st_act:   w_next = w_zero ? c_st_write : c_st_trcd;
            c_st_trcd:  if (w_zero) w_next = c_st_write;
            c_st_write: w_next = w_zero ? c_st_data : c_st_wlat;
            c_st_wlat:  if (w_zero) w_next = c_st_data;
            c_st_data:  w_next = c_st_twr;
            c_st_twr:   if (w_zero) w_next = c_st_pre;
            c_st_pre:   w_next = w_zero ? c_st_idle : c_st_trp;
            c_st_trp:   if (w_zero) w_next = c_st_idle;
            default:    w_next = c_st_idle;
        endcase
    end

    always_comb begin
        w_load     = starts_wait(w_next) && (w_next != r_state);
        w_load_val = '0;
        case (w_next)
            c_st_act:   w_load_val = c_ld_trcd;
            c_st_write: w_load_val = c_ld_wrlat;
            c_st_twr:   w_load_val = c_ld_twr;
            c_st_pre:   w_load_val = c_ld_trp;
            default:    w_load_val = '0;
        endcase
    end

    dfi_timer #(
        .WIDTH (c_timer_w)
    ) u_timer (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .i_load  (w_load),
        .i_value (w_load_val),
        .o_zero  (w_zero)
    );

    assign dfi_address_p1 = '0;
    assign dfi_bank_p1    = '0;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state            <= c_st_idle;
            req_ready          <= 1'b0;
            busy               <= 1'b0;
            r_col              <= '0;
            r_ba               <= '0;
            r_data             <= '0;
            r_mask             <= '0;
            {dfi_cs_n_p0, dfi_ras_n_p0, dfi_cas_n_p0, dfi_we_n_p0} <= c_cmd_nop;
            dfi_address_p0     <= '0;
            dfi_bank_p0        <= '0;
            dfi_wrdata_en_p0   <= 1'b0;
            dfi_wrdata_en_p1   <= 1'b0;
            dfi_wrdata_p0      <= '0;
            dfi_wrdata_p1      <= '0;
            dfi_wrdata_mask_p0 <= '0;
            dfi_wrdata_mask_p1 <= '0;
        end else begin
            r_state   <= w_next;
            req_ready <= (w_next == c_st_idle);
            busy      <= (w_next != c_st_idle);

            if (w_accept) begin
                r_col  <= req_col;
                r_ba   <= req_ba;
                r_data <= req_data;
                r_mask <= req_mask;
            end

            {dfi_cs_n_p0, dfi_ras_n_p0, dfi_cas_n_p0, dfi_we_n_p0} <= c_cmd_nop;
            dfi_address_p0     <= '0;
            dfi_bank_p0        <= '0;
            dfi_wrdata_en_p0   <= 1'b0;
            dfi_wrdata_en_p1   <= 1'b0;
            dfi_wrdata_p0      <= '0;
            dfi_wrdata_p1      <= '0;
            dfi_wrdata_mask_p0 <= '0;
            dfi_wrdata_mask_p1 <= '0;

            // None of these states loops on itself, so each decodes once.
            case (w_next)
                c_st_act: begin
                    // Row/bank come straight from the request: ACT is
                    // driven on the cycle right after acceptance.
                    {dfi_cs_n_p0, dfi_ras_n_p0, dfi_cas_n_p0, dfi_we_n_p0} <= c_cmd_act;
                    dfi_address_p0 <= req_row;
                    dfi_bank_p0    <= req_ba;
                end
                c_st_write: begin
                    {dfi_cs_n_p0, dfi_ras_n_p0, dfi_cas_n_p0, dfi_we_n_p0} <= c_cmd_write;
                    dfi_address_p0 <= r_col & ~c_a10;
                    dfi_bank_p0    <= r_ba;
                end
                c_st_data: begin
                    dfi_wrdata_en_p0   <= 1'b1;
                    dfi_wrdata_en_p1   <= 1'b1;
                    dfi_wrdata_p0      <= r_data[NUM_D-1:0];
                    dfi_wrdata_p1      <= r_data[2*NUM_D-1:NUM_D];
                    dfi_wrdata_mask_p0 <= r_mask[NUM_D/8-1:0];
                    dfi_wrdata_mask_p1 <= r_mask[NUM_D/4-1:NUM_D/8];
                end
                c_st_pre: begin
                    {dfi_cs_n_p0, dfi_ras_n_p0, dfi_cas_n_p0, dfi_we_n_p0} <= c_cmd_pre;
                    dfi_bank_p0 <= r_ba;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
